// File: rtl/viterbi_pack_pkg.sv
// Shared helpers for the Viterbi bit packer: width derivation, parameter
// sanity check and the lane-to-bit-position mapping.
package viterbi_pack_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Number of input beats that make up one output word.
  function automatic int ratio_of(input int in_w, input int out_w);
    return (in_w >= 1) ? (out_w / in_w) : 0;
  endfunction

  // Width needed to carry a beat count of 1..RATIO.
  function automatic int bw_of(input int in_w, input int out_w);
    return clog2(ratio_of(in_w, out_w) + 1);
  endfunction

  function automatic bit params_ok(input int in_w, input int out_w);
    return (in_w >= 1) && ((out_w % in_w) == 0) && ((out_w / in_w) >= 2);
  endfunction

  // Lowest bit index of lane 'lane' inside the packed word.
  function automatic int lane_lo(input int lane, input int in_w, input int out_w,
                                 input bit msb_first);
    return msb_first ? (out_w - (lane + 1) * in_w) : (lane * in_w);
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream holding register carrying tdata/tuser/tlast.
// A new word may only be loaded when the slot is empty or draining.
module axis_out_reg #(
  parameter int DATA_W = 8,
  parameter int USER_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] word_data,
  input  logic [USER_W-1:0] word_user,
  input  logic              word_last,
  input  logic              tready,
  output logic              tvalid,
  output logic [DATA_W-1:0] tdata,
  output logic [USER_W-1:0] tuser,
  output logic              tlast
);

  // Output stage: capture a completed word, release it on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tvalid <= 1'b0;
      tdata  <= '0;
      tuser  <= '0;
      tlast  <= 1'b0;
    end else if (load) begin
      tvalid <= 1'b1;
      tdata  <= word_data;
      tuser  <= word_user;
      tlast  <= word_last;
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/viterbi_bit_packer.sv
// Packs IN_WIDTH-bit hard decisions from the Viterbi decoder into
// OUT_WIDTH-bit words for the deinterleaver, closing partial words on tlast.
module viterbi_bit_packer
  import viterbi_pack_pkg::*;
#(
  parameter int IN_WIDTH  = 1,
  parameter int OUT_WIDTH = 8,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 32,
  localparam int RATIO    = ratio_of(IN_WIDTH, OUT_WIDTH),
  localparam int BW       = bw_of(IN_WIDTH, OUT_WIDTH)
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 cfg_enable,
  input  logic [IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [OUT_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic [BW-1:0]        m_axis_tuser,
  output logic [CNT_W-1:0]     stat_frames,
  output logic [CNT_W-1:0]     stat_partial
);

  if (!params_ok(IN_WIDTH, OUT_WIDTH)) begin : g_param_check
    $error("viterbi_bit_packer: OUT_WIDTH must be a multiple of IN_WIDTH with ratio >= 2");
  end

  logic                 run_p0;
  logic [OUT_WIDTH-1:0] acc_p0;
  logic [OUT_WIDTH-1:0] merged_p0;
  logic [BW-1:0]        cnt_p0;
  logic [BW-1:0]        word_user_p0;
  logic                 accept_p0;
  logic                 word_done_p0;
  logic                 frame_out;

  // run_p0 keeps tready low while reset is held and for the first edge after.
  assign s_axis_tready = run_p0 && cfg_enable && (!m_axis_tvalid || m_axis_tready);
  assign accept_p0     = s_axis_tvalid && s_axis_tready;
  assign word_done_p0  = accept_p0 && (s_axis_tlast || (cnt_p0 == BW'(RATIO - 1)));
  assign word_user_p0  = cnt_p0 + BW'(1);
  assign frame_out     = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  // Insert the current beat into its lane of the accumulator.
  always_comb begin
    merged_p0 = acc_p0;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt_p0 == BW'(k))
        merged_p0[lane_lo(k, IN_WIDTH, OUT_WIDTH, MSB_FIRST != 0) +: IN_WIDTH] = s_axis_tdata;
    end
  end

  // Track whether the block is out of reset.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) run_p0 <= 1'b0;
    else          run_p0 <= 1'b1;
  end

  // Accumulation stage: fill lanes, clear once the word hands off.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
    end else if (word_done_p0) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
    end else if (accept_p0) begin
      acc_p0 <= merged_p0;
      cnt_p0 <= cnt_p0 + BW'(1);
    end
  end

  axis_out_reg #(
    .DATA_W (OUT_WIDTH),
    .USER_W (BW)
  ) u_out (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .load      (word_done_p0),
    .word_data (merged_p0),
    .word_user (word_user_p0),
    .word_last (s_axis_tlast),
    .tready    (m_axis_tready),
    .tvalid    (m_axis_tvalid),
    .tdata     (m_axis_tdata),
    .tuser     (m_axis_tuser),
    .tlast     (m_axis_tlast)
  );

  // Frame statistics, counted when the closing word leaves the block.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      stat_frames  <= '0;
      stat_partial <= '0;
    end else if (frame_out) begin
      stat_frames <= stat_frames + CNT_W'(1);
      if (m_axis_tuser < BW'(RATIO))
        stat_partial <= stat_partial + CNT_W'(1);
    end
  end

endmodule

// File: doc/viterbi_bit_packer.md
Name: viterbi_bit_packer

Overview:
- Parametrised successor to the viterbi_to_deinterleaver adapter.
- Accepts hard-decision bit groups from the Viterbi decoder on an AXI4-Stream slave and packs them into OUT_WIDTH-bit words for the deinterleaver on an AXI4-Stream master.
- Handles frame boundaries (tlast) with zero-padded partial words, selectable bit order, and frame/partial statistics.
- Sits between the Viterbi decoder core and the deinterleaver inside the FEC receive chain.

Parameters:
- IN_WIDTH, 1, bits per input beat; must be ≥1.
- OUT_WIDTH, 8, bits per output word; must be a multiple of IN_WIDTH.
- MSB_FIRST, 1, 1: first beat lands in the top lane; 0: first beat lands in lane 0.
- CNT_W, 32, width of the statistics counters.
- Derived constant RATIO = OUT_WIDTH/IN_WIDTH; must be ≥2.
- Derived constant BW = clog2(RATIO+1).

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- cfg_enable  in  1  1 = accept input; 0 = stall input (output continues draining).
- s_axis_tdata  in  IN_WIDTH  decoded bits.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last beat of frame.
- m_axis_tdata  out  OUT_WIDTH  packed word.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  word closes a frame.
- m_axis_tuser  out  BW  number of valid beats in the word (1..RATIO).
- stat_frames  out  CNT_W  count of frames emitted.
- stat_partial  out  CNT_W  count of frames that ended on a partial word.

Behaviour:
- Reset values (async on ARESETN low):
  - All outputs 0; s_axis_tready 0.
  - Accumulator, beat counter, output register and both counters cleared.
  - Reset mid-word discards the partial word and any pending output; no tlast is emitted for the interrupted frame.
- Storage:
  - Accumulator acc[OUT_WIDTH], beat counter cnt[0..RATIO-1].
  - One output holding register (tdata/tuser/tlast/tvalid).
- Ready rule:
  - s_axis_tready = cfg_enable && (!m_axis_tvalid || m_axis_tready), registered-equivalent combinational.
  - No combinational path from s_axis_tvalid to s_axis_tready.
- Input beat accepted (tvalid && tready):
  - Written into lane cnt of acc. Lane k occupies bits [OUT_WIDTH-1-k*IN_WIDTH -: IN_WIDTH] if MSB_FIRST=1, otherwise [k*IN_WIDTH +: IN_WIDTH].
  - Word completes when cnt==RATIO-1 or s_axis_tlast=1.
- Word completion:
  - Output register loads the merged word (acc with the current beat inserted) on the same edge.
  - Unfilled lanes are 0. tuser = cnt+1. tlast = s_axis_tlast.
  - acc and cnt clear.
  - Latency: completing beat accepted at edge N, so m_axis_tvalid is high after edge N.
- Word not complete: cnt increments; acc holds the inserted lane.
- Output handshake:
  - m_axis_tvalid drops after a handshake unless a new word loads on the same edge.
  - Back-to-back operation sustains 1 input beat/cycle with continuous m_axis_tready.
  - While m_axis_tvalid && !m_axis_tready, data/tuser/tlast are stable.
- Statistics:
  - On an output handshake with tlast=1, stat_frames++.
  - If that word's tuser<RATIO, stat_partial++ as well.
  - Both counters wrap modulo 2^CNT_W silently.
- cfg_enable deasserted mid-word:
  - Accumulator and cnt hold; a pending output word still drains.
  - Re-enable resumes at the held lane.
- tlast on the first beat of a word gives a single-lane word, tuser=1.
- Exactly-full word with tlast: tuser=RATIO, not counted as partial.

Decomposition:
- Package viterbi_pack_pkg holds:
  - the lane-index function (MSB_FIRST mapping);
  - clog2 and the RATIO/BW derivation;
  - elaboration checks (OUT_WIDTH % IN_WIDTH == 0, RATIO ≥ 2).
- One sub-module, axis_out_reg: a single-entry AXI-Stream output holding register with tdata/tuser/tlast payload.
- The packer core instantiates axis_out_reg; the counters live in the top level.

Test Plan:
- Defaults, 16 beats of bit pattern 1,0,1,1,0,0,1,0 repeated, m_axis_tready=1, tlast on beat 16 → two words 0xB2, 0xB2; tuser=8 on both; tlast only on the second; stat_frames=1, stat_partial=0; s_axis_tready never drops.
- MSB_FIRST=0, same stimulus → words 0x4D, 0x4D.
- Frame of 11 beats, all 1, tlast on beat 11 → 0xFF (tuser=8), then 0xE0 (tuser=3, tlast=1); stat_partial=1.
- IN_WIDTH=2, OUT_WIDTH=8, beats 3,0,2,1 → 0xC9, tuser=4. Hold m_axis_tready=0 for 5 cycles → s_axis_tready=0, output stable, no beat lost. Release → next word follows with one cycle of latency.
- cfg_enable dropped after 3 of 8 beats for 10 cycles → no further accept; resume completes the correct word. Assert ARESETN low after 5 beats of a new frame → all outputs 0, stat counters 0, and the next frame packs from lane 0.
- CNT_W=4, 17 frames of 1 beat each → stat_frames=1 (wrap); stat_partial=1.
